// File: rtl/vga_pll_pkg.sv
// Shared types and sizing helpers for the VGA PLL supervisor.
// State encoding, counter widths and the timer-width function live here.
package vga_pll_pkg;

  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 16;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return cnt_w(m);
  endfunction

endpackage

// File: rtl/vga_pll_lock_sync.sv
// Two-flop synchroniser bringing the PLL locked flag into the refclk domain.
// Both flops clear on the synchronous reset so the FSM starts from "unlocked".
module vga_pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/vga_pll_supervisor.sv
// PLL reset sequencer: pulse, wait for lock with timeout/retry, qualify, run, watch for loss.
// Optional macro LOCK_LOSS_CNT_EN adds the saturating loss_cnt port and counter.
module vga_pll_supervisor
  import vga_pll_pkg::*;
#(
  parameter int RST_PULSE_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC  = 50000,
  parameter int LOCK_STABLE_CYC   = 1024,
  parameter int UNLOCK_FILTER_CYC = 4,
  parameter int MAX_RETRIES       = 4
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               domain_rst,
  output logic               pll_ready,
  output logic               lock_fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);

  localparam int TW = timer_w(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, UNLOCK_FILTER_CYC);
  localparam int FW = cnt_w(UNLOCK_FILTER_CYC);

  localparam logic [TW-1:0]      RST_LAST  = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]      STB_LAST  = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [FW-1:0]      FILT_LAST = FW'(UNLOCK_FILTER_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic lk_s;

  vga_pll_lock_sync u_lock_sync (
    .clk      (refclk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (lk_s)
  );

  // state is kept as a plain named signal so checkers can bind to it.
  pll_state_e         state, state_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [FW-1:0]      filt, filt_nx;
  logic [RETRY_W-1:0] retry_nx;

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    filt_nx  = '0;
    case (state)
      PLL_RST: begin
        if (timer == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (lk_s) begin
          state_nx = STABLE;
        end else if (timer == TO_LAST) begin
          retry_nx = retry_cnt + RETRY_W'(1);
          state_nx = (retry_nx == RETRY_MAX) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_nx = WAIT_LOCK;
        end else if (timer == STB_LAST) begin
          state_nx = RUN;
          retry_nx = '0;
        end
      end
      RUN: begin
        if (!lk_s) begin
          if (filt == FILT_LAST) state_nx = PLL_RST;
          else                   filt_nx  = filt + FW'(1);
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = PLL_RST;
      end
    endcase

    // One shared timer: restarts on every transition, idles in RUN and FAIL.
    if (state_nx != state)                          timer_nx = '0;
    else if (state == RUN || state == FAIL)         timer_nx = timer;
    else                                            timer_nx = timer + TW'(1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= PLL_RST;
      timer      <= '0;
      filt       <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= 1'b1;
      pll_ready  <= 1'b0;
      lock_fail  <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      filt       <= filt_nx;
      retry_cnt  <= retry_nx;
      // Outputs decode the next state so they change on the entering edge.
      pll_rst    <= (state_nx == PLL_RST) || (state_nx == FAIL);
      domain_rst <= (state_nx != RUN);
      pll_ready  <= (state_nx == RUN);
      lock_fail  <= (state_nx == FAIL);
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && (state_nx == PLL_RST);

  always_ff @(posedge refclk) begin
    if (rst)                              loss_cnt <= '0;
    else if (loss_evt && loss_cnt != '1)  loss_cnt <= loss_cnt + LOSS_W'(1);
  end
`endif

endmodule

// File: tb/tb_vga_pll_supervisor.sv
// Directed bench for vga_pll_supervisor with short cycle parameters.
// Edge numbers in comments count refclk edges after the last reset edge (E0).
module tb_vga_pll_supervisor;

  localparam int W = 3;

  logic        refclk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        pll_rst;
  logic        domain_rst;
  logic        pll_ready;
  logic        lock_fail;
  logic [7:0]  retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  vga_pll_supervisor #(
    .RST_PULSE_CYC     (4),
    .LOCK_TIMEOUT_CYC  (20),
    .LOCK_STABLE_CYC   (8),
    .UNLOCK_FILTER_CYC (3),
    .MAX_RETRIES       (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .domain_rst (domain_rst),
    .pll_ready  (pll_ready),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  // clock / reset
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"},    32'(pll_rst),    32'd1);
    check({tag, "_domain_rst"}, 32'(domain_rst), 32'd1);
    check({tag, "_pll_ready"},  32'(pll_ready),  32'd0);
    check({tag, "_lock_fail"},  32'(lock_fail),  32'd0);
    check({tag, "_retry_cnt"},  32'(retry_cnt),  32'd0);
`ifdef LOCK_LOSS_CNT_EN
    check({tag, "_loss_cnt"},   32'(loss_cnt),   32'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] exp_v;

    rst        = 1'b1;
    pll_locked = 1'b1;
    step(2);
    rst = 1'b0;
    check_reset_vals("reset");

    // 1: lock present from the start; pll_rst E0..E3, RUN entered on E13.
    for (int k = 1; k <= 15; k++)
      exp_q.push_back({(k <= 3) ? 1'b1 : 1'b0, (k < 13) ? 1'b1 : 1'b0, (k >= 13) ? 1'b1 : 1'b0});
    while (exp_q.size() > 0) begin
      step(1);
      exp_v = exp_q.pop_front();
      check("t1_seq", 32'({pll_rst, domain_rst, pll_ready}), 32'(exp_v));
    end
    check("t1_retry", 32'(retry_cnt), 32'd0);

    // 3a: two-cycle dropout is filtered.
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(5);
    check("t3_glitch_ready", 32'(pll_ready), 32'd1);
    check("t3_glitch_drst",  32'(domain_rst), 32'd0);

    // 3b: three-cycle dropout; FSM sees lk_s low on A3..A5 and leaves RUN on A5.
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(1);
    check("t3_pre_ready", 32'(pll_ready), 32'd1);
    step(1);
    check("t3_loss_ready", 32'(pll_ready), 32'd0);
    check("t3_loss_drst",  32'(domain_rst), 32'd1);
    check("t3_loss_prst",  32'(pll_rst), 32'd1);
`ifdef LOCK_LOSS_CNT_EN
    check("t3_loss_cnt", 32'(loss_cnt), 32'd1);
`endif
    step(3);
    check("t3_prst_hold", 32'(pll_rst), 32'd1);
    step(1);
    check("t3_prst_end", 32'(pll_rst), 32'd0);
    step(8);
    check("t3_relock_early", 32'(pll_ready), 32'd0);
    step(1);
    check("t3_relock_ready", 32'(pll_ready), 32'd1);

    // 4: lock drops while in STABLE; back to WAIT_LOCK at E10, RUN at E21.
    do_reset();
`ifdef LOCK_LOSS_CNT_EN
    check("t4_loss_cleared", 32'(loss_cnt), 32'd0);
`endif
    step(7);
    pll_locked = 1'b0;
    step(3);
    check("t4_wait_prst",  32'(pll_rst), 32'd0);
    check("t4_wait_drst",  32'(domain_rst), 32'd1);
    check("t4_wait_retry", 32'(retry_cnt), 32'd0);
    pll_locked = 1'b1;
    step(10);
    check("t4_not_yet", 32'(pll_ready), 32'd0);
    step(1);
    check("t4_ready", 32'(pll_ready), 32'd1);
    check("t4_retry", 32'(retry_cnt), 32'd0);

    // 5: first attempt times out on E24, second attempt locks, RUN on E37.
    pll_locked = 1'b0;
    do_reset();
    step(23);
    check("t5_pre_to_retry", 32'(retry_cnt), 32'd0);
    step(1);
    check("t5_to_retry", 32'(retry_cnt), 32'd1);
    check("t5_to_prst",  32'(pll_rst), 32'd1);
    pll_locked = 1'b1;
    step(12);
    check("t5_not_yet",    32'(pll_ready), 32'd0);
    check("t5_retry_held", 32'(retry_cnt), 32'd1);
    step(1);
    check("t5_ready",       32'(pll_ready), 32'd1);
    check("t5_retry_clear", 32'(retry_cnt), 32'd0);

    // 2: no lock; attempts end on E24 and E48, second failure enters FAIL.
    pll_locked = 1'b0;
    do_reset();
    step(23);
    check("t2_a1_retry", 32'(retry_cnt), 32'd0);
    check("t2_a1_prst",  32'(pll_rst), 32'd0);
    step(1);
    check("t2_r1_retry", 32'(retry_cnt), 32'd1);
    check("t2_r1_prst",  32'(pll_rst), 32'd1);
    check("t2_r1_fail",  32'(lock_fail), 32'd0);
    step(23);
    check("t2_a2_prst",  32'(pll_rst), 32'd0);
    check("t2_a2_retry", 32'(retry_cnt), 32'd1);
    step(1);
    check("t2_fail_retry", 32'(retry_cnt), 32'd2);
    check("t2_fail_flag",  32'(lock_fail), 32'd1);
    check("t2_fail_prst",  32'(pll_rst), 32'd1);
    check("t2_fail_drst",  32'(domain_rst), 32'd1);
    pll_locked = 1'b1;
    step(30);
    check("t2_sticky_flag",  32'(lock_fail), 32'd1);
    check("t2_sticky_prst",  32'(pll_rst), 32'd1);
    check("t2_sticky_ready", 32'(pll_ready), 32'd0);
    check("t2_sticky_retry", 32'(retry_cnt), 32'd2);

    // 6a: rst out of FAIL restarts the full sequence.
    do_reset();
    check_reset_vals("t6_fail_rst");
    step(12);
    check("t6a_not_yet", 32'(pll_ready), 32'd0);
    step(1);
    check("t6a_ready", 32'(pll_ready), 32'd1);

    // 6b: rst while in STABLE.
    do_reset();
    step(7);
    do_reset();
    check_reset_vals("t6_stable_rst");
    step(3);
    check("t6b_prst_hold", 32'(pll_rst), 32'd1);
    step(1);
    check("t6b_prst_end", 32'(pll_rst), 32'd0);
    step(8);
    check("t6b_not_yet", 32'(pll_ready), 32'd0);
    step(1);
    check("t6b_ready", 32'(pll_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
